pcs_10g_dec_lite: RTL and testbench

Receive-side 64b/66b PCS decoder for the 10GBASE-R path. It is the counterpart of the lite transmit encoder. It takes descrambled, block-aligned 66-bit blocks (sync header plus 64-bit payload) and produces XGMII-style per-block flags, data and byte keep. A two-state packet FSM checks block sequencing and flags protocol violations. The block sits between the descrambler/block-lock stage and the MAC receive interface.

---
 rtl/pcs_10g_dec_lite.sv | 208 ++++++++++++++++++++
 tb/tb_pcs_10g_dec_lite.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_10g_dec_lite.sv
// 64b/66b receive decoder (lite): turns descrambled 66-bit blocks into
// XGMII-style per-block flags, data and byte keep. It tracks packet sequencing
// and keeps a saturating count of errored blocks. Latency is one cycle.
module pcs_10g_dec_lite #(
    parameter int unsigned XGMII_DATA_W = 64,
    parameter int unsigned XGMII_KEEP_W = 8,
    parameter int unsigned BLOCK_TYPE_W = 8,
    parameter int unsigned ERR_CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    head_v_i,
    input  logic [1:0]              sync_head_i,
    input  logic [XGMII_DATA_W-1:0] data_i,
    output logic                    valid_o,
    output logic                    ctrl_v_o,
    output logic                    idle_v_o,
    output logic                    start_o,
    output logic                    term_o,
    output logic                    err_o,
    output logic [XGMII_DATA_W-1:0] data_o,
    output logic [XGMII_KEEP_W-1:0] keep_o,
    output logic [ERR_CNT_W-1:0]    err_cnt_o
);

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [BLOCK_TYPE_W-1:0] TYPE_IDLE  = BLOCK_TYPE_W'(8'h1e);
    localparam logic [BLOCK_TYPE_W-1:0] TYPE_START = BLOCK_TYPE_W'(8'h78);

    typedef enum logic { RX_IDLE, RX_DATA } rx_state_e;
    typedef enum logic [2:0] { BLK_DATA, BLK_IDLE, BLK_START, BLK_TERM, BLK_BAD } blk_kind_e;

    rx_state_e               state_q, state_d;
    logic                    valid_q, valid_d;
    logic                    ctrl_v_q, ctrl_v_d;
    logic                    idle_v_q, idle_v_d;
    logic                    start_q, start_d;
    logic                    term_q, term_d;
    logic                    err_q, err_d;
    logic [XGMII_DATA_W-1:0] data_q, data_d;
    logic [XGMII_KEEP_W-1:0] keep_q, keep_d;
    logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;

    blk_kind_e               blk_kind;
    logic                    blk_ctrl;
    logic [XGMII_DATA_W-1:0] blk_data;
    logic [XGMII_KEEP_W-1:0] blk_keep;
    logic [BLOCK_TYPE_W-1:0] blk_type;
    logic                    all_idle;
    logic                    is_term;
    logic [2:0]              term_lanes;
    logic [XGMII_DATA_W-1:0] term_data;
    logic                    seq_err;

    // Classify the incoming block and build its decoded data/keep.
    always_comb begin
        blk_type = data_i[BLOCK_TYPE_W-1:0];

        all_idle = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            if (data_i[8 + 7*i +: 7] != 7'h07) begin
                all_idle = 1'b0;
            end
        end

        is_term    = 1'b1;
        term_lanes = 3'd0;
        case (blk_type)
            BLOCK_TYPE_W'(8'h87): term_lanes = 3'd0;
            BLOCK_TYPE_W'(8'h99): term_lanes = 3'd1;
            BLOCK_TYPE_W'(8'haa): term_lanes = 3'd2;
            BLOCK_TYPE_W'(8'hb4): term_lanes = 3'd3;
            BLOCK_TYPE_W'(8'hcc): term_lanes = 3'd4;
            BLOCK_TYPE_W'(8'hd2): term_lanes = 3'd5;
            BLOCK_TYPE_W'(8'he1): term_lanes = 3'd6;
            BLOCK_TYPE_W'(8'hff): term_lanes = 3'd7;
            default:              is_term    = 1'b0;
        endcase

        term_data = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            if (i < 32'(term_lanes)) begin
                term_data[8*i +: 8] = data_i[8*(i+1) +: 8];
            end
        end

        blk_kind = BLK_BAD;
        blk_ctrl = 1'b0;
        blk_data = '0;
        blk_keep = '0;
        case (sync_head_i)
            SYNC_DATA: begin
                blk_kind = BLK_DATA;
                blk_data = data_i;
                blk_keep = '1;
            end
            SYNC_CTRL: begin
                blk_ctrl = 1'b1;
                if (blk_type == TYPE_IDLE) begin
                    blk_kind = all_idle ? BLK_IDLE : BLK_BAD;
                end else if (blk_type == TYPE_START) begin
                    blk_kind = BLK_START;
                    blk_data = {data_i[XGMII_DATA_W-1:8], 8'hFB};
                    blk_keep = {{(XGMII_KEEP_W-1){1'b1}}, 1'b0};
                end else if (is_term) begin
                    blk_kind = BLK_TERM;
                    blk_data = term_data;
                    blk_keep = XGMII_KEEP_W'((32'd1 << term_lanes) - 32'd1);
                end
            end
            default: blk_kind = BLK_BAD;
        endcase
    end

    // Packet sequencing, output flag generation and error counting.
    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        ctrl_v_d  = 1'b0;
        idle_v_d  = 1'b0;
        start_d   = 1'b0;
        term_d    = 1'b0;
        err_d     = 1'b0;
        data_d    = data_q;
        keep_d    = keep_q;
        err_cnt_d = err_cnt_q;
        seq_err   = 1'b0;

        if (head_v_i) begin
            valid_d  = 1'b1;
            ctrl_v_d = blk_ctrl;
            idle_v_d = (blk_kind == BLK_IDLE);
            start_d  = (blk_kind == BLK_START);
            term_d   = (blk_kind == BLK_TERM);
            data_d   = blk_data;
            keep_d   = blk_keep;

            case (state_q)
                RX_IDLE: begin
                    if (blk_kind == BLK_START) begin
                        state_d = RX_DATA;
                    end
                    seq_err = (blk_kind == BLK_DATA) || (blk_kind == BLK_TERM);
                end
                RX_DATA: begin
                    case (blk_kind)
                        BLK_DATA:  state_d = RX_DATA;
                        BLK_START: begin
                            state_d = RX_DATA;
                            seq_err = 1'b1;
                        end
                        BLK_IDLE: begin
                            state_d = RX_IDLE;
                            seq_err = 1'b1;
                        end
                        default:   state_d = RX_IDLE;
                    endcase
                end
                default: state_d = RX_IDLE;
            endcase

            err_d = (blk_kind == BLK_BAD) || seq_err;
            if (err_d && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= RX_IDLE;
            valid_q   <= 1'b0;
            ctrl_v_q  <= 1'b0;
            idle_v_q  <= 1'b0;
            start_q   <= 1'b0;
            term_q    <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            ctrl_v_q  <= ctrl_v_d;
            idle_v_q  <= idle_v_d;
            start_q   <= start_d;
            term_q    <= term_d;
            err_q     <= err_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign valid_o   = valid_q;
    assign ctrl_v_o  = ctrl_v_q;
    assign idle_v_o  = idle_v_q;
    assign start_o   = start_q;
    assign term_o    = term_q;
    assign err_o     = err_q;
    assign data_o    = data_q;
    assign keep_o    = keep_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_pcs_10g_dec_lite.sv
// Scoreboard bench for pcs_10g_dec_lite: directed sequences plus random blocks,
// checked against a block-level reference model. A second instance with a
// narrow error counter exercises saturation.
module tb_pcs_10g_dec_lite;

    localparam int K_DATA  = 0;
    localparam int K_IDLE  = 1;
    localparam int K_START = 2;
    localparam int K_TERM  = 3;
    localparam int K_BAD   = 4;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        head_v_i = 1'b0;
    logic [1:0]  sync_head_i = 2'b00;
    logic [63:0] data_i = '0;

    logic        a_valid, a_ctrl, a_idle, a_start, a_term, a_err;
    logic [63:0] a_data;
    logic [7:0]  a_keep;
    logic [15:0] a_cnt;

    logic        b_valid, b_ctrl, b_idle, b_start, b_term, b_err;
    logic [63:0] b_data;
    logic [7:0]  b_keep;
    logic [3:0]  b_cnt;

    pcs_10g_dec_lite #(.ERR_CNT_W(16)) u_dut (
        .clk(clk), .nreset(nreset), .head_v_i(head_v_i), .sync_head_i(sync_head_i),
        .data_i(data_i), .valid_o(a_valid), .ctrl_v_o(a_ctrl), .idle_v_o(a_idle),
        .start_o(a_start), .term_o(a_term), .err_o(a_err), .data_o(a_data),
        .keep_o(a_keep), .err_cnt_o(a_cnt)
    );

    pcs_10g_dec_lite #(.ERR_CNT_W(4)) u_dut_sat (
        .clk(clk), .nreset(nreset), .head_v_i(head_v_i), .sync_head_i(sync_head_i),
        .data_i(data_i), .valid_o(b_valid), .ctrl_v_o(b_ctrl), .idle_v_o(b_idle),
        .start_o(b_start), .term_o(b_term), .err_o(b_err), .data_o(b_data),
        .keep_o(b_keep), .err_cnt_o(b_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  flags;     // {valid, ctrl, idle, start, term, err}
        logic [7:0]  keep;
        logic [63:0] data;
        logic        chk_data;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic        m_in_pkt = 1'b0;
    int          m_cnt = 0;
    int          m_cnt4 = 0;
    logic [7:0]  m_keep = '0;
    logic [63:0] m_data = '0;
    logic        m_data_known = 1'b1;

    logic [7:0]  term_types [8] = '{8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};
    logic [55:0] idle_payload = {8{7'h07}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Drive one block (or a gap when v=0) and queue the model's expectation.
    task automatic send(input logic v, input logic [1:0] sync, input logic [63:0] d);
        exp_t e;
        int   kind;
        int   k;
        logic err;
        @(negedge clk);
        nreset      = 1'b1;
        head_v_i    = v;
        sync_head_i = sync;
        data_i      = d;
        e.flags    = '0;
        e.keep     = m_keep;
        e.data     = m_data;
        e.chk_data = m_data_known;
        if (v) begin
            kind       = K_BAD;
            k          = 0;
            e.data     = '0;
            e.keep     = '0;
            e.chk_data = 1'b0;
            if (sync == 2'b01) begin
                kind       = K_DATA;
                e.data     = d;
                e.keep     = 8'hFF;
                e.chk_data = 1'b1;
            end else if (sync == 2'b10) begin
                if (d[7:0] == 8'h1e && d[63:8] == idle_payload) begin
                    kind = K_IDLE;
                end else if (d[7:0] == 8'h78) begin
                    kind       = K_START;
                    e.data     = (d & ~64'hFF) | 64'hFB;
                    e.keep     = 8'hFE;
                    e.chk_data = 1'b1;
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        if (d[7:0] == term_types[i]) begin
                            kind = K_TERM;
                            k    = i;
                        end
                    end
                    if (kind == K_TERM) begin
                        e.data     = (d >> 8) & ((64'd1 << (8 * k)) - 64'd1);
                        e.keep     = 8'((1 << k) - 1);
                        e.chk_data = 1'b1;
                    end
                end
            end
            err = (kind == K_BAD)
               || (!m_in_pkt && (kind == K_DATA || kind == K_TERM))
               || ( m_in_pkt && (kind == K_IDLE || kind == K_START));
            m_in_pkt = (kind == K_START) || (kind == K_DATA && m_in_pkt);
            if (err && m_cnt < 65535) m_cnt++;
            if (err && m_cnt4 < 15) m_cnt4++;
            e.flags = {1'b1, sync == 2'b10, kind == K_IDLE, kind == K_START, kind == K_TERM, err};
            m_keep       = e.keep;
            m_data       = e.data;
            m_data_known = e.chk_data;
        end
        e.cnt  = 16'(m_cnt);
        e.cnt4 = 4'(m_cnt4);
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        nreset      = 1'b0;
        head_v_i    = 1'($urandom_range(0, 1));
        sync_head_i = 2'($urandom_range(0, 3));
        data_i      = rand64();
        m_in_pkt = 1'b0; m_cnt = 0; m_cnt4 = 0;
        m_keep = '0; m_data = '0; m_data_known = 1'b1;
        e.flags = '0; e.keep = '0; e.data = '0; e.chk_data = 1'b1; e.cnt = '0; e.cnt4 = '0;
        sb_q.push_back(e);
    endtask

    task automatic send_idle();  send(1'b1, 2'b10, {idle_payload, 8'h1e}); endtask
    task automatic send_data();  send(1'b1, 2'b01, rand64()); endtask
    task automatic send_start(); send(1'b1, 2'b10, {rand64() >> 8, 8'h78}); endtask
    task automatic send_term(input int k);
        logic [63:0] d;
        d = rand64();
        d[7:0] = term_types[k];
        send(1'b1, 2'b10, d);
    endtask

    task automatic send_random();
        int          r;
        logic [63:0] d;
        logic [7:0]  t;
        r = $urandom_range(0, 99);
        if (r < 8) send(1'b0, 2'($urandom_range(0, 3)), rand64());
        else if (r < 30) send_data();
        else if (r < 42) send_idle();
        else if (r < 45) begin
            d = {idle_payload, 8'h1e};
            d[8 + 7 * $urandom_range(0, 7)] ^= 1'b1;
            send(1'b1, 2'b10, d);
        end
        else if (r < 58) send_start();
        else if (r < 80) send_term($urandom_range(0, 7));
        else if (r < 88) begin
            t = 8'($urandom());
            if (t == 8'h1e || t == 8'h78) t = 8'h2d;
            for (int i = 0; i < 8; i++) if (t == term_types[i]) t = 8'h4b;
            d = rand64();
            d[7:0] = t;
            send(1'b1, 2'b10, d);
        end
        else if (r < 94) send(1'b1, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, rand64());
        else if (r < 96) do_reset();
        else send_data();
    endtask

    // Monitor: one expectation per cycle, compared 2 time units after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("flags", 64'({a_valid, a_ctrl, a_idle, a_start, a_term, a_err}), 64'(e.flags));
                check("keep", 64'(a_keep), 64'(e.keep));
                if (e.chk_data) check("data", a_data, e.data);
                check("err_cnt", 64'(a_cnt), 64'(e.cnt));
                check("sat_flags", 64'({b_valid, b_ctrl, b_idle, b_start, b_term, b_err}), 64'(e.flags));
                check("sat_keep", 64'(b_keep), 64'(e.keep));
                if (e.chk_data) check("sat_data", b_data, e.data);
                check("sat_err_cnt", 64'(b_cnt), 64'(e.cnt4));
            end else if (a_valid === 1'b1) begin
                check("unexpected_valid", 64'(a_valid), 64'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        do_reset();
        do_reset();

        // Idle stream
        repeat (3) send_idle();

        // Clean packet ending in term_3 with bytes AA BB CC
        send_start();
        send_data();
        send_data();
        d = rand64();
        d[31:0] = 32'hCCBB_AAB4;
        send(1'b1, 2'b10, d);
        send_idle();

        // Data in idle, then idle inside a packet
        send_data();
        send_start();
        send_data();
        send_idle();
        send_idle();

        // Bad sync header and unsupported ordered set
        send(1'b1, 2'b11, rand64());
        d = rand64();
        d[7:0] = 8'h2d;
        send(1'b1, 2'b10, d);

        // Gap in the middle of a packet, then term_0
        send_start();
        send_data();
        repeat (4) send(1'b0, 2'($urandom_range(0, 3)), rand64());
        send_term(0);

        // Reset mid-packet with a non-zero error count, then a stray term
        send(1'b1, 2'b00, rand64());
        send(1'b1, 2'b11, rand64());
        send_start();
        send_data();
        do_reset();
        send_term(3);

        // Every term lane count inside valid packets
        for (int k = 0; k < 8; k++) begin
            send_start();
            send_term(k);
        end

        repeat (800) send_random();

        send(1'b0, 2'b00, '0);
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
